div_unit: RTL and testbench

- Multi-cycle 32-bit divider attached to the EX stage, serving DIV/DIVU; result is written to HI/LO downstream.
- EX issues start_i and stalls the pipeline until ready_o is high.
- Restoring radix-2 algorithm, one quotient bit per clock; the shift/subtract datapath runs in parallel with the EX shift/ALU path.

---
 rtl/div_unit.sv | 106 ++++++++++
 tb/tb_div_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle restoring radix-2 divider for DIV/DIVU; one quotient bit per clock.
// result_o = {remainder, quotient}, valid while ready_o is high.
module div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               signed_div_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic               start_i,
   input  logic               annul_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o
);

   typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   dvd;   // dividend bits shift out the top, quotient bits shift in the bottom
   logic [WIDTH-1:0]   dsr;
   logic [WIDTH-1:0]   rem;
   logic               neg_q;
   logic               neg_r;

   logic [WIDTH-1:0]   a_abs, b_abs;
   logic [WIDTH:0]     trial;
   logic [WIDTH-1:0]   q_fix, r_fix;

   always_comb begin
      a_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
      b_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
      // rem < dsr always holds, so the WIDTH+1 bit difference is negative iff its top bit is set
      trial = {rem, dvd[WIDTH-1]} - {1'b0, dsr};
      q_fix = neg_q ? -dvd : dvd;
      r_fix = neg_r ? -rem : rem;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= FREE;
         cnt      <= '0;
         dvd      <= '0;
         dsr      <= '0;
         rem      <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         result_o <= '0;
         ready_o  <= 1'b0;
      end else begin
         case (state)
            FREE: begin
               ready_o  <= 1'b0;
               result_o <= '0;
               if (start_i && !annul_i) begin
                  dvd   <= a_abs;
                  dsr   <= b_abs;
                  rem   <= '0;
                  cnt   <= '0;
                  neg_q <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                  neg_r <= signed_div_i && opdata1_i[WIDTH-1];
                  state <= (opdata2_i == '0) ? BYZERO : ON;
               end
            end
            BYZERO: begin
               if (annul_i) begin
                  state <= FREE;
               end else begin
                  result_o <= '0;
                  ready_o  <= 1'b1;
                  state    <= END;
               end
            end
            ON: begin
               if (annul_i) begin
                  state <= FREE;
               end else if (cnt == CNT_W'(WIDTH)) begin
                  result_o <= {r_fix, q_fix};
                  ready_o  <= 1'b1;
                  state    <= END;
               end else begin
                  if (!trial[WIDTH]) begin
                     rem <= trial[WIDTH-1:0];
                     dvd <= {dvd[WIDTH-2:0], 1'b1};
                  end else begin
                     rem <= {rem[WIDTH-2:0], dvd[WIDTH-1]};
                     dvd <= {dvd[WIDTH-2:0], 1'b0};
                  end
                  cnt <= cnt + 1'b1;
               end
            end
            END: begin
               if (!start_i) begin
                  result_o <= '0;
                  ready_o  <= 1'b0;
                  state    <= FREE;
               end
            end
            default: state <= FREE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver queues expected results, monitor checks them on ready rise.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        signed_div = 1'b0;
   logic [31:0] op1 = '0, op2 = '0;
   logic        start = 1'b0, annul = 1'b0;
   logic [63:0] result;
   logic        ready;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   typedef struct {
      logic [63:0] res;
      int          e0;
      int          lat;
      string       name;
   } exp_t;
   exp_t sbq[$];

   div_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .signed_div_i(signed_div),
      .opdata1_i(op1), .opdata2_i(op2), .start_i(start), .annul_i(annul),
      .result_o(result), .ready_o(ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] model(bit sgn, logic [31:0] a, logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 0) return 64'd0;
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = sa / sb;
         r  = sa % sb;
         return {r[31:0], q[31:0]};
      end
      return {a % b, a / b};
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pop on every ready rise, then hold-check the result while ready stays high.
   logic        ready_q = 1'b0;
   logic [63:0] held = '0;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         if (ready && !ready_q) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ready: got result %h expected no ready", result);
            end else begin
               e = sbq.pop_front();
               check(e.name, result, e.res);
               check({e.name, "_lat"}, 64'(cyc - e.e0), 64'(e.lat));
            end
            held <= result;
         end else if (ready && ready_q) begin
            check("hold", result, held);
         end
      end
      ready_q <= ready;
   end

   task automatic issue(bit sgn, logic [31:0] a, logic [31:0] b);
      @(negedge clk);
      signed_div = sgn;
      op1 = a;
      op2 = b;
      start = 1'b1;
   endtask

   task automatic wait_ready(string name);
      for (int i = 0; i < 40 && !ready; i++) begin
         @(negedge clk);
         op1 = $urandom;
         op2 = $urandom;
      end
      if (!ready) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got ready=0 expected ready=1", name);
         if (sbq.size() != 0) void'(sbq.pop_front());
      end
   endtask

   task automatic run_op(bit sgn, logic [31:0] a, logic [31:0] b, logic [63:0] exp,
                         string name, int hold);
      issue(sgn, a, b);
      sbq.push_back('{res: exp, e0: cyc + 1, lat: (b == 0) ? 1 : 33, name: name});
      wait_ready(name);
      repeat (hold) @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check({name, "_drop_rdy"}, {63'd0, ready}, 64'd0);
      check({name, "_drop_res"}, result, 64'd0);
   endtask

   initial begin
      logic [31:0] a, b;
      bit          sgn;

      @(negedge clk);
      check("reset_ready", {63'd0, ready}, 64'd0);
      check("reset_result", result, 64'd0);
      rst = 1'b1;

      run_op(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, "divu_100_7", 3);
      run_op(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, "div_m7_2", 0);
      run_op(1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, "div_7_m2", 1);
      run_op(1'b0, 32'h12345678, 32'd0, 64'd0, "divu_by_zero", 2);
      run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, "div_min_m1", 0);
      run_op(1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, "divu_max_1", 1);
      run_op(1'b1, 32'h80000000, 32'd0, 64'd0, "div_by_zero", 0);

      // Annul mid-operation: no result may ever appear.
      issue(1'b0, 32'd1000, 32'd3);
      repeat (10) @(negedge clk);
      annul = 1'b1;
      @(negedge clk);
      annul = 1'b0;
      start = 1'b0;
      check("annul_ready", {63'd0, ready}, 64'd0);
      check("annul_result", result, 64'd0);
      repeat (40) @(negedge clk);
      run_op(1'b0, 32'd9, 32'd4, 64'h00000001_00000002, "after_annul_9_4", 0);

      // start dropped during ON: operation completes, END lasts one cycle.
      issue(1'b0, 32'd100, 32'd7);
      sbq.push_back('{res: 64'h00000002_0000000E, e0: cyc + 1, lat: 33, name: "drop_in_on"});
      repeat (5) @(negedge clk);
      start = 1'b0;
      wait_ready("drop_in_on");
      @(negedge clk);
      check("drop_in_on_exit_rdy", {63'd0, ready}, 64'd0);

      // Asynchronous reset between E15 and E16.
      issue(1'b0, 32'd1000, 32'd3);
      repeat (16) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("rst_on_ready", {63'd0, ready}, 64'd0);
      check("rst_on_result", result, 64'd0);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (40) @(negedge clk);
      run_op(1'b0, 32'd20, 32'd6, 64'h00000002_00000003, "after_rst_20_6", 0);

      // Asynchronous reset while a result is being held.
      issue(1'b1, 32'hFFFFFFF1, 32'd4);
      sbq.push_back('{res: model(1'b1, 32'hFFFFFFF1, 32'd4), e0: cyc + 1, lat: 33, name: "rst_end_op"});
      wait_ready("rst_end_op");
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("rst_end_ready", {63'd0, ready}, 64'd0);
      check("rst_end_result", result, 64'd0);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      // Randomized operations against the arithmetic model.
      for (int n = 0; n < 30; n++) begin
         sgn = 1'($urandom);
         a = $urandom;
         case ($urandom_range(0, 3))
            0: b = 32'($urandom_range(1, 15));
            1: b = (n % 5 == 0) ? 32'd0 : $urandom;
            2: b = -32'($urandom_range(1, 300));
            default: b = $urandom >> $urandom_range(0, 31);
         endcase
         run_op(sgn, a, b, model(sgn, a, b), "rand", $urandom_range(0, 3));
      end

      repeat (3) @(negedge clk);
      if (sbq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
